// File: rtl/gb_exec_core.sv
// Executes LD r,r' / LD r,n / INC r / DEC r / HALT from a valid/ready byte stream.
// The register file has a debug read/write port for test access.
module gb_exec_core #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned DBG_EN   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        op_valid,
    input  logic [7:0]                  op_data,
    output logic                        op_ready,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_rd_sel,
    output logic [DATA_W-1:0]           dbg_rd_data,
    input  logic                        dbg_wr_en,
    input  logic [$clog2(NUM_REGS)-1:0] dbg_wr_sel,
    input  logic [DATA_W-1:0]           dbg_wr_data,
    output logic                        instr_done,
    output logic                        illegal,
    output logic                        z_flag,
    output logic                        halted
);

    localparam int unsigned SEL_W = $clog2(NUM_REGS);
    localparam int unsigned OP_W  = 8;

    typedef enum logic [1:0] {ST_FETCH, ST_IMM, ST_EXEC, ST_HALT} state_t;
    typedef enum logic [2:0] {K_LD_RR, K_LD_RN, K_INC, K_DEC, K_HALT, K_ILL} kind_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     op_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    kind_t               exec_kind;
    logic [SEL_W-1:0]    dst;
    logic [SEL_W-1:0]    src;
    logic [DATA_W-1:0]   result;
    logic                core_we;
    logic                dbg_we;

    // Classify an opcode byte; any operand field naming (HL) makes it illegal.
    function automatic kind_t decode(input logic [OP_W-1:0] b);
        kind_t k;
        k = K_ILL;
        if (b == 8'h76) begin
            k = K_HALT;
        end else if (b[7:6] == 2'b01) begin
            if (b[5:3] != 3'd6 && b[2:0] != 3'd6) k = K_LD_RR;
        end else if (b[7:6] == 2'b00 && b[5:3] != 3'd6) begin
            case (b[2:0])
                3'd6:    k = K_LD_RN;
                3'd4:    k = K_INC;
                3'd5:    k = K_DEC;
                default: k = K_ILL;
            endcase
        end
        return k;
    endfunction

    assign exec_kind = decode(op_q);
    assign dst       = SEL_W'(op_q[5:3]);
    assign src       = SEL_W'(op_q[2:0]);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_FETCH;
        else     state_q <= state_d;
    end

    // Next state and Moore outputs
    always_comb begin
        state_d    = state_q;
        op_ready   = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    case (decode(op_data))
                        K_LD_RN: state_d = ST_IMM;
                        K_HALT:  state_d = ST_HALT;
                        default: state_d = ST_EXEC;
                    endcase
                end
            end
            ST_IMM: begin
                op_ready = 1'b1;
                if (op_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                instr_done = 1'b1;
                illegal    = (exec_kind == K_ILL);
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Source mux: register, immediate, or reg[d] +/- 1 wrapping at 2^DATA_W
    always_comb begin
        result  = '0;
        core_we = 1'b0;
        case (exec_kind)
            K_LD_RR: begin result = regs[src];               core_we = 1'b1; end
            K_LD_RN: begin result = imm_q;                   core_we = 1'b1; end
            K_INC:   begin result = regs[dst] + DATA_W'(1);  core_we = 1'b1; end
            K_DEC:   begin result = regs[dst] - DATA_W'(1);  core_we = 1'b1; end
            default: begin result = '0;                      core_we = 1'b0; end
        endcase
        if (state_q != ST_EXEC) core_we = 1'b0;
    end

    // A debug write colliding with the core write on the same index is dropped.
    assign dbg_we = (DBG_EN != 0) && dbg_wr_en && !(core_we && (dbg_wr_sel == dst));

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            imm_q  <= '0;
            z_flag <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[SEL_W'(i)] <= '0;
        end else begin
            if (state_q == ST_FETCH && op_valid) op_q  <= op_data;
            if (state_q == ST_IMM && op_valid)   imm_q <= DATA_W'(op_data);
            if (dbg_we)  regs[dbg_wr_sel] <= dbg_wr_data;
            if (core_we) regs[dst]        <= result;
            if (state_q == ST_EXEC && (exec_kind == K_INC || exec_kind == K_DEC))
                z_flag <= (result == '0);
        end
    end

    assign dbg_rd_data = regs[dbg_rd_sel];

endmodule

// File: tb/tb_gb_exec_core.sv
// Bench for gb_exec_core: directed scenarios plus random opcode stream,
// with a scoreboard monitor checking every retired instruction.
module tb_gb_exec_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [7:0] op_data = 8'h00;
    logic       op_ready;
    logic [2:0] dbg_rd_sel = 3'd0;
    logic [7:0] dbg_rd_data;
    logic       dbg_wr_en = 1'b0;
    logic [2:0] dbg_wr_sel = 3'd0;
    logic [7:0] dbg_wr_data = 8'h00;
    logic       instr_done;
    logic       illegal;
    logic       z_flag;
    logic       halted;

    gb_exec_core #(.DATA_W(8), .NUM_REGS(8), .DBG_EN(1)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
        .dbg_rd_sel(dbg_rd_sel), .dbg_rd_data(dbg_rd_data),
        .dbg_wr_en(dbg_wr_en), .dbg_wr_sel(dbg_wr_sel), .dbg_wr_data(dbg_wr_data),
        .instr_done(instr_done), .illegal(illegal), .z_flag(z_flag), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: register file and zero flag
    logic [7:0] mr [8];
    bit         mz;

    typedef struct {bit ill; bit z;} exp_t;
    exp_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) mr[i] = 8'h00;
        mz = 1'b0;
    endfunction

    // Architectural effect of one instruction (HALT handled separately)
    function automatic void model_instr(input logic [7:0] opc, input logic [7:0] imm);
        int grp = int'(opc) / 64;
        int d   = (int'(opc) / 8) % 8;
        int s   = int'(opc) % 8;
        bit ill = 1'b1;
        exp_t e;
        if (grp == 1 && d != 6 && s != 6) begin
            mr[d] = mr[s]; ill = 1'b0;
        end else if (grp == 0 && d != 6 && s == 6) begin
            mr[d] = imm; ill = 1'b0;
        end else if (grp == 0 && d != 6 && s == 4) begin
            mr[d] = 8'((int'(mr[d]) + 1) % 256); mz = (mr[d] == 8'h00); ill = 1'b0;
        end else if (grp == 0 && d != 6 && s == 5) begin
            mr[d] = 8'((int'(mr[d]) + 255) % 256); mz = (mr[d] == 8'h00); ill = 1'b0;
        end
        e.ill = ill;
        e.z   = mz;
        q.push_back(e);
    endfunction

    // Monitor: one expectation per EXEC cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (instr_done === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr_done: got instr_done=1 expected none at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("illegal", int'(illegal), int'(e.ill));
                    @(posedge clk);
                    #1;
                    chk("z_flag", int'(z_flag), int'(e.z));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_data  = b;
        while (op_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: op_ready stuck low, byte 0x%0h not accepted", b);
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (op_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: core never returned to fetch");
        end
    endtask

    task automatic dbg_write(input int sel, input logic [7:0] data);
        wait_idle();
        dbg_wr_en   = 1'b1;
        dbg_wr_sel  = 3'(sel);
        dbg_wr_data = data;
        @(posedge clk);
        #1;
        dbg_wr_en = 1'b0;
        mr[sel] = data;
    endtask

    task automatic check_reg(input int idx, input string name);
        dbg_rd_sel = 3'(idx);
        #1;
        chk(name, int'(dbg_rd_data), int'(mr[idx]));
    endtask

    task automatic check_all(input string name);
        wait_idle();
        for (int i = 0; i < 8; i++) check_reg(i, name);
    endtask

    // LD r,n whose EXEC cycle carries a debug write
    task automatic ldn_with_dbg(input logic [7:0] opc, input logic [7:0] imm,
                                input int sel, input logic [7:0] data);
        int d = (int'(opc) / 8) % 8;
        send(opc);
        send(imm);
        model_instr(opc, imm);
        dbg_wr_en   = 1'b1;
        dbg_wr_sel  = 3'(sel);
        dbg_wr_data = data;
        @(posedge clk);
        #1;
        dbg_wr_en = 1'b0;
        if (sel != d) mr[sel] = data;
    endtask

    initial begin
        logic [7:0] opc;
        logic [7:0] imm;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_op_ready", int'(op_ready), 1);
        chk("rst_instr_done", int'(instr_done), 0);
        chk("rst_illegal", int'(illegal), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_z_flag", int'(z_flag), 0);
        check_all("rst_reg");

        // LD A,B with EXEC-cycle observation of pre-write value
        dbg_write(0, 8'h5A);
        send(8'h78);
        chk("exec_op_ready", int'(op_ready), 0);
        chk("exec_instr_done", int'(instr_done), 1);
        dbg_rd_sel = 3'd7;
        #1;
        chk("exec_prewrite_A", int'(dbg_rd_data), 0);
        model_instr(8'h78, 8'h00);
        wait_idle();
        check_reg(7, "ld_a_b");

        // INC C wraps to zero
        dbg_write(1, 8'hFF);
        send(8'h0C);
        model_instr(8'h0C, 8'h00);
        wait_idle();
        check_reg(1, "inc_c_wrap");

        // LD A,n with idle cycles in IMM; z_flag must stay set
        send(8'h3E);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("imm_wait_ready", int'(op_ready), 1);
        end
        send(8'h00);
        model_instr(8'h3E, 8'h00);
        wait_idle();
        check_reg(7, "ld_a_imm");

        // DEC C wraps back
        send(8'h0D);
        model_instr(8'h0D, 8'h00);
        wait_idle();
        check_reg(1, "dec_c_wrap");

        // Illegal opcodes leave registers alone
        send(8'h46);
        model_instr(8'h46, 8'h00);
        send(8'hC3);
        model_instr(8'hC3, 8'h00);
        check_all("illegal_regs");

        // Debug write collisions during EXEC
        ldn_with_dbg(8'h06, 8'h11, 0, 8'h22);
        check_all("dbg_collide");
        ldn_with_dbg(8'h06, 8'h44, 2, 8'h33);
        check_all("dbg_alongside");

        // HALT holds with op_valid high, only reset exits
        send(8'h76);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op_valid = 1'b1;
            op_data  = 8'($urandom);
            chk("halt_halted", int'(halted), 1);
            chk("halt_op_ready", int'(op_ready), 0);
        end
        @(negedge clk);
        op_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("halt_rst_op_ready", int'(op_ready), 1);
        chk("halt_rst_halted", int'(halted), 0);
        chk("halt_rst_z", int'(z_flag), 0);
        check_all("halt_rst_reg");

        // Reset while waiting for an immediate
        dbg_write(0, 8'h9C);
        send(8'h06);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("imm_rst_op_ready", int'(op_ready), 1);
        check_reg(0, "imm_rst_B");
        send(8'h04);
        model_instr(8'h04, 8'h00);
        wait_idle();
        check_reg(0, "after_rst_opcode");

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 9) == 0) dbg_write($urandom_range(0, 7), 8'($urandom));
            opc = 8'($urandom);
            if (opc == 8'h76) opc = 8'h00;
            imm = 8'($urandom);
            send(opc);
            if ((opc & 8'hC7) == 8'h06 && opc != 8'h36) send(imm);
            model_instr(opc, imm);
            if (n % 25 == 24) check_all("rand_regs");
        end
        check_all("final_regs");

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
